// File: rtl/cv32e40x_amo_responder.sv
// RV32A atomic responder: plain accesses pass through, AMO/LR/SC run as RMW.
// Optional MIN/MAX/MINU/MAXU support under `CV32E40X_AMO_MINMAX_EN.
module cv32e40x_amo_responder #(
  parameter int unsigned LRSC_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req_i,
  output logic        core_gnt_o,
  input  logic [31:0] core_addr_i,
  input  logic        core_we_i,
  input  logic [3:0]  core_be_i,
  input  logic [31:0] core_wdata_i,
  input  logic [5:0]  core_atop_i,
  output logic        core_rvalid_o,
  output logic [31:0] core_rdata_o,
  output logic        core_err_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i
);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RESP
  } state_e;

  localparam logic [4:0] F_ADD  = 5'b00000;
  localparam logic [4:0] F_SWAP = 5'b00001;
  localparam logic [4:0] F_LR   = 5'b00010;
  localparam logic [4:0] F_SC   = 5'b00011;
  localparam logic [4:0] F_XOR  = 5'b00100;
  localparam logic [4:0] F_OR   = 5'b01000;
  localparam logic [4:0] F_AND  = 5'b01100;
`ifdef CV32E40X_AMO_MINMAX_EN
  localparam logic [4:0] F_MIN  = 5'b10000;
  localparam logic [4:0] F_MAX  = 5'b10100;
  localparam logic [4:0] F_MINU = 5'b11000;
  localparam logic [4:0] F_MAXU = 5'b11100;
`endif

  state_e      state_q, state_d;
  logic [31:0] addr_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [5:0]  atop_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        res_valid_q;
  logic [29:0] res_addr_q;
  logic [9:0]  cnt_q;

  logic        legal_f5;
  logic        in_amo, in_bad, in_sc, in_hit;
  logic        q_amo, q_lr;
  logic        rd_done, lr_done, wr_fire;
  logic [31:0] amo_new;

  // Classify the incoming funct5
  always_comb begin
    legal_f5 = 1'b0;
    case (core_atop_i[4:0])
      F_ADD, F_SWAP, F_LR, F_SC,
      F_XOR, F_OR, F_AND: legal_f5 = 1'b1;
`ifdef CV32E40X_AMO_MINMAX_EN
      F_MIN, F_MAX,
      F_MINU, F_MAXU:     legal_f5 = 1'b1;
`endif
      default:            legal_f5 = 1'b0;
    endcase
  end

  assign in_amo = core_atop_i[5];
  assign in_bad = in_amo &
                  ((|core_addr_i[1:0]) | ~legal_f5);
  assign in_sc  = in_amo & ~in_bad &
                  (core_atop_i[4:0] == F_SC);
  assign in_hit = res_valid_q &
                  (res_addr_q == core_addr_i[31:2]);

  assign q_amo   = atop_q[5];
  assign q_lr    = q_amo & (atop_q[4:0] == F_LR);
  assign rd_done = (state_q == RD_WAIT) & mem_rvalid_i;
  assign lr_done = rd_done & ~mem_err_i & q_lr;
  assign wr_fire = mem_req_o & mem_we_o & mem_gnt_i;

  // New memory word from old word and operand
  always_comb begin
    amo_new = wdata_q;
    case (atop_q[4:0])
      F_ADD:  amo_new = mem_rdata_i + wdata_q;
      F_XOR:  amo_new = mem_rdata_i ^ wdata_q;
      F_OR:   amo_new = mem_rdata_i | wdata_q;
      F_AND:  amo_new = mem_rdata_i & wdata_q;
`ifdef CV32E40X_AMO_MINMAX_EN
      F_MIN:  amo_new = ($signed(mem_rdata_i) < $signed(wdata_q))
                        ? mem_rdata_i : wdata_q;
      F_MAX:  amo_new = ($signed(mem_rdata_i) > $signed(wdata_q))
                        ? mem_rdata_i : wdata_q;
      F_MINU: amo_new = (mem_rdata_i < wdata_q)
                        ? mem_rdata_i : wdata_q;
      F_MAXU: amo_new = (mem_rdata_i > wdata_q)
                        ? mem_rdata_i : wdata_q;
`endif
      default: amo_new = wdata_q;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (core_req_i) begin
        unique case (1'b1)
          !in_amo:          state_d = RD_REQ;
          in_bad:           state_d = RESP;
          in_sc && in_hit:  state_d = WR_REQ;
          in_sc && !in_hit: state_d = RESP;
          default:          state_d = RD_REQ;
        endcase
      end
      RD_REQ:  if (mem_gnt_i) state_d = RD_WAIT;
      RD_WAIT: if (mem_rvalid_i)
        state_d = (mem_err_i | ~q_amo | q_lr) ? RESP : WR_REQ;
      WR_REQ:  if (mem_gnt_i) state_d = WR_WAIT;
      WR_WAIT: if (mem_rvalid_i) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Request latch and response datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      atop_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state_q == IDLE && core_req_i) begin
        addr_q  <= core_addr_i;
        we_q    <= core_we_i;
        be_q    <= core_be_i;
        wdata_q <= core_wdata_i;
        atop_q  <= core_atop_i;
        err_q   <= in_bad;
        rdata_q <= {31'b0, in_sc & ~in_hit};
      end
      if (rd_done) begin
        if (mem_err_i) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end else begin
          rdata_q <= mem_rdata_i;
          if (q_amo && !q_lr) wdata_q <= amo_new;
        end
      end
      if (state_q == WR_WAIT && mem_rvalid_i)
        err_q <= mem_err_i;
    end
  end

  // LR/SC reservation with timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_addr_q  <= '0;
      cnt_q       <= '0;
    end else begin
      if (res_valid_q) begin
        if (cnt_q <= 10'd1) begin
          res_valid_q <= 1'b0;
          cnt_q       <= '0;
        end else begin
          cnt_q <= cnt_q - 10'd1;
        end
      end
      if (state_q == IDLE && core_req_i && in_sc)
        res_valid_q <= 1'b0;
      if (wr_fire && mem_addr_o[31:2] == res_addr_q)
        res_valid_q <= 1'b0;
      if (rd_done && mem_err_i)
        res_valid_q <= 1'b0;
      if (lr_done) begin
        res_valid_q <= 1'b1;
        res_addr_q  <= addr_q[31:2];
        cnt_q       <= 10'(LRSC_TIMEOUT);
      end
    end
  end

  assign core_gnt_o    = (state_q == IDLE) & ~rst;
  assign core_rvalid_o = (state_q == RESP);
  assign core_rdata_o  = core_rvalid_o ? rdata_q : '0;
  assign core_err_o    = core_rvalid_o & err_q;

  assign mem_req_o   = (state_q == RD_REQ) | (state_q == WR_REQ);
  assign mem_we_o    = (state_q == WR_REQ) |
                       ((state_q == RD_REQ) & ~q_amo & we_q);
  assign mem_addr_o  = mem_req_o ? addr_q : '0;
  assign mem_be_o    = mem_req_o ? (q_amo ? 4'hF : be_q) : '0;
  assign mem_wdata_o = mem_req_o ? wdata_q : '0;

endmodule

// File: tb/tb_cv32e40x_amo_responder.sv
// Directed bench for cv32e40x_amo_responder.
// Bench memory grants same cycle, responds next cycle.
module tb_cv32e40x_amo_responder;

  localparam int TMO = 64;

  localparam logic [5:0] A_ADD  = 6'h20;
  localparam logic [5:0] A_SWAP = 6'h21;
  localparam logic [5:0] A_LR   = 6'h22;
  localparam logic [5:0] A_SC   = 6'h23;
  localparam logic [5:0] A_XOR  = 6'h24;
`ifdef CV32E40X_AMO_MINMAX_EN
  localparam logic [5:0] A_MIN  = 6'h30;
  localparam logic [5:0] A_MINU = 6'h38;
`else
  localparam logic [5:0] A_MAX  = 6'h34;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        core_req_i = 1'b0;
  logic        core_gnt_o;
  logic [31:0] core_addr_i = '0;
  logic        core_we_i = 1'b0;
  logic [3:0]  core_be_i = '0;
  logic [31:0] core_wdata_i = '0;
  logic [5:0]  core_atop_i = '0;
  logic        core_rvalid_o;
  logic [31:0] core_rdata_o;
  logic        core_err_o;
  logic        mem_req_o;
  logic        mem_gnt_i;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        mem_err_i = 1'b0;

  logic        gnt_en = 1'b1;
  logic        err_inject = 1'b0;
  logic [31:0] mem [0:1023];
  int          nreq = 0;
  int          nwr = 0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;
  assign mem_gnt_i = gnt_en;

  cv32e40x_amo_responder #(.LRSC_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .core_req_i(core_req_i), .core_gnt_o(core_gnt_o),
    .core_addr_i(core_addr_i), .core_we_i(core_we_i),
    .core_be_i(core_be_i), .core_wdata_i(core_wdata_i),
    .core_atop_i(core_atop_i),
    .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o),
    .core_err_o(core_err_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .mem_err_i(mem_err_i)
  );

  // Bench memory: same-cycle grant, next-cycle response
  always @(posedge clk) begin
    mem_rvalid_i <= 1'b0;
    if (mem_req_o && mem_gnt_i) begin
      mem_rvalid_i <= 1'b1;
      mem_err_i    <= err_inject;
      mem_rdata_i  <= mem[mem_addr_o[11:2]];
      nreq = nreq + 1;
      if (mem_we_o) begin
        nwr = nwr + 1;
        if (!err_inject)
          for (int b = 0; b < 4; b++)
            if (mem_be_o[b])
              mem[mem_addr_o[11:2]][8*b +: 8] = mem_wdata_o[8*b +: 8];
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic [31:0] a, input logic we,
                    input logic [3:0] be, input logic [31:0] wd,
                    input logic [5:0] at,
                    output logic [31:0] rd, output logic er,
                    output int lat);
    @(negedge clk);
    core_req_i = 1'b1; core_addr_i = a; core_we_i = we;
    core_be_i = be; core_wdata_i = wd; core_atop_i = at;
    @(posedge clk);
    @(negedge clk);
    core_req_i = 1'b0;
    lat = 1;
    while (!core_rvalid_o && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    rd = core_rdata_o;
    er = core_err_o;
    if (!core_rvalid_o) lat = -1;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          r0, w0;

    for (int i = 0; i < 1024; i++) mem[i] = '0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(core_gnt_o), 32'd0);
    chk("rst_rvalid", 32'(core_rvalid_o), 32'd0);
    chk("rst_rdata", core_rdata_o, 32'd0);
    chk("rst_err", 32'(core_err_o), 32'd0);
    chk("rst_mreq", 32'(mem_req_o), 32'd0);
    chk("rst_mwe", 32'(mem_we_o), 32'd0);
    chk("rst_maddr", mem_addr_o, 32'd0);
    chk("rst_mbe", 32'(mem_be_o), 32'd0);
    chk("rst_mwdata", mem_wdata_o, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_gnt", 32'(core_gnt_o), 32'd1);

    // Plain store then load
    w0 = nwr;
    op(32'h100, 1'b1, 4'hF, 32'hDEADBEEF, 6'h00, rd, er, lat);
    chk("st_lat", 32'(lat), 32'd3);
    chk("st_err", 32'(er), 32'd0);
    chk("st_nwr", 32'(nwr - w0), 32'd1);
    chk("st_mem", mem[32'h100 >> 2], 32'hDEADBEEF);
    op(32'h100, 1'b0, 4'hF, 32'h0, 6'h00, rd, er, lat);
    chk("ld_data", rd, 32'hDEADBEEF);
    chk("ld_err", 32'(er), 32'd0);
    chk("ld_lat", 32'(lat), 32'd3);
    chk("ld_nwr", 32'(nwr - w0), 32'd1);

    // AMOADD
    mem[32'h200 >> 2] = 32'd5;
    op(32'h200, 1'b0, 4'hF, 32'd3, A_ADD, rd, er, lat);
    chk("add_old", rd, 32'd5);
    chk("add_lat", 32'(lat), 32'd5);
    chk("add_mem", mem[32'h200 >> 2], 32'd8);

    // AMOXOR
    mem[32'h20C >> 2] = 32'hF0F0F0F0;
    op(32'h20C, 1'b0, 4'hF, 32'hFF00FF00, A_XOR, rd, er, lat);
    chk("xor_old", rd, 32'hF0F0F0F0);
    chk("xor_mem", mem[32'h20C >> 2], 32'h0FF00FF0);

`ifdef CV32E40X_AMO_MINMAX_EN
    mem[32'h204 >> 2] = 32'hFFFFFFFF;
    op(32'h204, 1'b0, 4'hF, 32'd1, A_MIN, rd, er, lat);
    chk("min_old", rd, 32'hFFFFFFFF);
    chk("min_mem", mem[32'h204 >> 2], 32'hFFFFFFFF);
    mem[32'h208 >> 2] = 32'hFFFFFFFF;
    op(32'h208, 1'b0, 4'hF, 32'd1, A_MINU, rd, er, lat);
    chk("minu_mem", mem[32'h208 >> 2], 32'd1);
    chk("minu_lat", 32'(lat), 32'd5);
`else
    r0 = nreq;
    op(32'h204, 1'b0, 4'hF, 32'd1, A_MAX, rd, er, lat);
    chk("max_err", 32'(er), 32'd1);
    chk("max_lat", 32'(lat), 32'd1);
    chk("max_rdata", rd, 32'd0);
    chk("max_noreq", 32'(nreq - r0), 32'd0);
`endif

    // LR then SC succeeds, second SC fails
    mem[32'h300 >> 2] = 32'h11;
    op(32'h300, 1'b0, 4'hF, 32'h0, A_LR, rd, er, lat);
    chk("lr_data", rd, 32'h11);
    chk("lr_lat", 32'(lat), 32'd3);
    op(32'h300, 1'b0, 4'hF, 32'd7, A_SC, rd, er, lat);
    chk("sc1_rd", rd, 32'd0);
    chk("sc1_lat", 32'(lat), 32'd3);
    chk("sc1_mem", mem[32'h300 >> 2], 32'd7);
    r0 = nreq;
    op(32'h300, 1'b0, 4'hF, 32'd9, A_SC, rd, er, lat);
    chk("sc2_rd", rd, 32'd1);
    chk("sc2_lat", 32'(lat), 32'd1);
    chk("sc2_noreq", 32'(nreq - r0), 32'd0);

    // Plain store to reserved word kills reservation
    op(32'h300, 1'b0, 4'hF, 32'h0, A_LR, rd, er, lat);
    op(32'h300, 1'b1, 4'hF, 32'd9, 6'h00, rd, er, lat);
    op(32'h300, 1'b0, 4'hF, 32'hAA, A_SC, rd, er, lat);
    chk("sc_st_rd", rd, 32'd1);
    chk("sc_st_mem", mem[32'h300 >> 2], 32'd9);

    // Reservation times out
    op(32'h300, 1'b0, 4'hF, 32'h0, A_LR, rd, er, lat);
    repeat (TMO + 1) @(negedge clk);
    op(32'h300, 1'b0, 4'hF, 32'hAA, A_SC, rd, er, lat);
    chk("sc_tmo_rd", rd, 32'd1);
    chk("sc_tmo_mem", mem[32'h300 >> 2], 32'd9);

    // Misaligned AMOSWAP
    r0 = nreq;
    op(32'h202, 1'b0, 4'hF, 32'h1, A_SWAP, rd, er, lat);
    chk("mis_err", 32'(er), 32'd1);
    chk("mis_lat", 32'(lat), 32'd1);
    chk("mis_rdata", rd, 32'd0);
    chk("mis_noreq", 32'(nreq - r0), 32'd0);

    // Stalled grant then read error
    r0 = nreq; w0 = nwr;
    gnt_en = 1'b0;
    @(negedge clk);
    core_req_i = 1'b1; core_addr_i = 32'h210; core_we_i = 1'b0;
    core_be_i = 4'h3; core_wdata_i = 32'd1; core_atop_i = A_ADD;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      core_req_i = 1'b0;
      chk("stall_req", 32'(mem_req_o), 32'd1);
      chk("stall_addr", mem_addr_o, 32'h210);
      chk("stall_we", 32'(mem_we_o), 32'd0);
      chk("stall_be", 32'(mem_be_o), 32'hF);
    end
    gnt_en = 1'b1;
    err_inject = 1'b1;
    lat = 0;
    while (!core_rvalid_o && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    err_inject = 1'b0;
    chk("rderr_rvalid", 32'(core_rvalid_o), 32'd1);
    chk("rderr_err", 32'(core_err_o), 32'd1);
    chk("rderr_rdata", core_rdata_o, 32'd0);
    chk("rderr_nreq", 32'(nreq - r0), 32'd1);
    chk("rderr_nwr", 32'(nwr - w0), 32'd0);

    // Reset during WR_WAIT also drops reservation
    op(32'h300, 1'b0, 4'hF, 32'h0, A_LR, rd, er, lat);
    @(negedge clk);
    core_req_i = 1'b1; core_addr_i = 32'h200; core_we_i = 1'b0;
    core_be_i = 4'hF; core_wdata_i = 32'd1; core_atop_i = A_ADD;
    @(posedge clk);
    repeat (4) begin
      @(negedge clk);
      core_req_i = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_rvalid", 32'(core_rvalid_o), 32'd0);
    chk("mrst_mreq", 32'(mem_req_o), 32'd0);
    chk("mrst_gnt", 32'(core_gnt_o), 32'd0);
    chk("mrst_maddr", mem_addr_o, 32'd0);
    chk("mrst_mwdata", mem_wdata_o, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_idle", 32'(core_gnt_o), 32'd1);
    chk("mrst_norv", 32'(core_rvalid_o), 32'd0);
    op(32'h300, 1'b0, 4'hF, 32'h55, A_SC, rd, er, lat);
    chk("mrst_sc", rd, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
